// File: rtl/cone_eval_scheduler.sv
//------------------------------------------------------------------------------
// Module      : cone_eval_scheduler
// Description : Round-robin scheduler that shares one fixed-latency cone evaluator
//               among NREQ requesters and returns tagged, backpressured responses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cone_eval_scheduler #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 6,
    parameter int CONE_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic [WIDTH-1:0]          cone_in,
    input  logic                      cone_out,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic                      rsp_data,
    input  logic                      rsp_ready,
    output logic                      busy,
    output logic [CNT_W-1:0]          txn_count
);

    localparam int IDW   = $clog2(NREQ);
    localparam int LAT_W = $clog2(CONE_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDW-1:0]     r_ptr;
    logic [LAT_W-1:0]   r_lat;
    logic [IDW-1:0]     w_win;
    logic [IDW-1:0]     w_cand;
    logic               w_found;
    logic               w_accept;

    // Scan from the slot after the last winner, wrapping, so priority rotates.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = IDW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && w_found;
    assign busy     = (r_state != S_IDLE);

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_WAIT;
            S_WAIT:  if (r_lat == LAT_W'(1)) w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cone_in   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= 1'b0;
            txn_count <= '0;
            r_ptr     <= IDW'(NREQ - 1);
            r_lat     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        cone_in <= req_data[w_win*WIDTH +: WIDTH];
                        rsp_id  <= w_win;
                        r_ptr   <= w_win;
                        r_lat   <= LAT_W'(CONE_LAT);
                    end
                end
                S_WAIT: begin
                    // cone_in has been stable for CONE_LAT cycles when r_lat reaches 1.
                    if (r_lat == LAT_W'(1)) begin
                        rsp_data  <= cone_out;
                        rsp_valid <= 1'b1;
                    end
                    r_lat <= r_lat - LAT_W'(1);
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cone_eval_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_cone_eval_scheduler
// Description : Scoreboard bench driving two scheduler instances (CONE_LAT=2/CNT_W=16
//               and CONE_LAT=1/CNT_W=4) from shared stimulus against a cycle model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cone_eval_scheduler;

    localparam int c_nreq  = 4;
    localparam int c_width = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [23:0] req_data;
    logic        rsp_ready;

    logic [3:0]  rr0, rr1;
    logic [5:0]  ci0, ci1;
    logic        rv0, rv1, rd0, rd1, bz0, bz1;
    logic [1:0]  rid0, rid1;
    logic [15:0] tc0;
    logic [3:0]  tc1;

    int n_total = 0;
    int n_bad   = 0;
    logic mon_en = 1'b0;

    // Cycle model state, one slot per instance
    int         m_st[2];
    int         m_cnt[2];
    int         m_ptr[2];
    int         m_txn[2];
    int         m_rid[2];
    logic       m_rd[2];
    logic [5:0] m_cone[2];
    int         q0[$];
    int         q1[$];

    always #5 clk = ~clk;

    cone_eval_scheduler #(.NREQ(4), .WIDTH(6), .CONE_LAT(2), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rr0), .cone_in(ci0), .cone_out(ci0[1]), .rsp_valid(rv0),
        .rsp_id(rid0), .rsp_data(rd0), .rsp_ready(rsp_ready), .busy(bz0),
        .txn_count(tc0)
    );

    cone_eval_scheduler #(.NREQ(4), .WIDTH(6), .CONE_LAT(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rr1), .cone_in(ci1), .cone_out(ci1[1]), .rsp_valid(rv1),
        .rsp_id(rid1), .rsp_data(rd1), .rsp_ready(rsp_ready), .busy(bz1),
        .txn_count(tc1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int u);
        m_st[u]   = 0;
        m_cnt[u]  = 0;
        m_ptr[u]  = c_nreq - 1;
        m_txn[u]  = 0;
        m_rid[u]  = 0;
        m_rd[u]   = 1'b0;
        m_cone[u] = '0;
        if (u == 0) q0.delete(); else q1.delete();
    endtask

    task automatic model_step(input int u, input int lat, input int cmask,
                              input logic [3:0] rr, input logic [5:0] ci,
                              input logic rv, input logic [1:0] rid, input logic rd,
                              input logic bz, input logic [15:0] tc);
        int         win;
        logic       found;
        logic [3:0] exp_rr;
        int         front;
        string      pfx;
        pfx   = (u == 0) ? "u0" : "u1";
        found = 1'b0;
        win   = 0;
        for (int k = 1; k <= c_nreq; k++) begin
            int idx;
            idx = (m_ptr[u] + k) % c_nreq;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        exp_rr = '0;
        if (m_st[u] == 0 && found) exp_rr[win] = 1'b1;

        chk({pfx, "_req_ready"}, 32'(rr), 32'(exp_rr));
        chk({pfx, "_busy"},      32'(bz), 32'(m_st[u] != 0));
        chk({pfx, "_rsp_valid"}, 32'(rv), 32'(m_st[u] == 2));
        chk({pfx, "_cone_in"},   32'(ci), 32'(m_cone[u]));
        chk({pfx, "_rsp_id"},    32'(rid), 32'(m_rid[u]));
        chk({pfx, "_rsp_data"},  32'(rd), 32'(m_rd[u]));
        chk({pfx, "_txn_count"}, 32'(tc), 32'(m_txn[u] & cmask));
        if (m_st[u] == 2) begin
            if (u == 0) front = (q0.size() > 0) ? q0[0] : -1;
            else        front = (q1.size() > 0) ? q1[0] : -1;
            chk({pfx, "_sb_rsp"}, 32'({rid, rd}), 32'(front));
        end

        if (rst) begin
            model_reset(u);
        end else begin
            case (m_st[u])
                0: if (found) begin
                    m_cone[u] = req_data[win*c_width +: c_width];
                    m_rid[u]  = win;
                    m_ptr[u]  = win;
                    m_cnt[u]  = lat;
                    m_st[u]   = 1;
                    if (u == 0) q0.push_back(win * 2 + int'(m_cone[u][1]));
                    else        q1.push_back(win * 2 + int'(m_cone[u][1]));
                end
                1: begin
                    if (m_cnt[u] == 1) begin
                        m_rd[u] = m_cone[u][1];
                        m_st[u] = 2;
                    end
                    m_cnt[u] = m_cnt[u] - 1;
                end
                2: if (rsp_ready) begin
                    if (u == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    m_txn[u] = m_txn[u] + 1;
                    m_st[u]  = 0;
                end
                default: ;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            model_step(0, 2, 16'hFFFF, rr0, ci0, rv0, rid0, rd0, bz0, tc0);
            model_step(1, 1, 16'h000F, rr1, ci1, rv1, rid1, rd1, bz1, 16'(tc1));
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        tick(2);
        model_reset(0);
        model_reset(1);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick(1);

        // Single request from requester 2 carrying 6'h2A
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        req_data  = 24'h2A << 12;
        tick(1);
        req_valid = '0;
        tick(6);

        // Reset while both instances are in WAIT; the in-flight request is dropped
        req_valid = 4'hF;
        req_data  = 24'($urandom);
        tick(1);
        req_valid = '0;
        rst       = 1'b1;
        tick(1);
        rst = 1'b0;

        // All requesters continuously valid: rotation 0,1,2,3,0...
        req_valid = 4'hF;
        for (int i = 0; i < 40; i++) begin
            req_data = 24'($urandom);
            tick(1);
        end

        // Response backpressure
        rsp_ready = 1'b0;
        tick(12);
        rsp_ready = 1'b1;
        tick(5);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            req_valid = 4'($urandom);
            req_data  = 24'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        tick(10);
        mon_en = 1'b0;
        chk("u0_min_txns", 32'(m_txn[0] >= 20), 32'd1);
        chk("u1_min_txns", 32'(m_txn[1] >= 20), 32'd1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
